// File: rtl/uart_aes_pkg.sv
// uart_aes_pkg: shared types and constants for the AES-over-UART receive path.
//   rx_state_t  - byte receiver FSM states (PARITY only when UART_RX_PARITY_EN is defined)
//   BLOCK_BYTES / BYTE_W / BLOCK_W - block geometry (16 bytes, 8 bits, 128 bits)
//   BYTE_CNT_W  - width of the byte-within-block counter
// Optional feature macro: UART_RX_PARITY_EN (adds even-parity bit, 8E1 frames).
package uart_aes_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_W     = 128;
    localparam int BYTE_CNT_W  = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_block128_if.sv
// uart_rx_block128_if: serial input and block output bundle of the block receiver.
//   en_rx     - receiver enable
//   rx        - asynchronous serial line, idle high
//   data_out  - last complete 128-bit block (first byte in [127:120])
//   u_rx_done - one-cycle block-complete strobe
//   frame_err - one-cycle bad stop bit / parity strobe
//   busy      - frame in progress or partial block held
// master: side that drives the line and consumes blocks; slave: the receiver.
interface uart_rx_block128_if;
    import uart_aes_pkg::*;

    logic               en_rx;
    logic               rx;
    logic [BLOCK_W-1:0] data_out;
    logic               u_rx_done;
    logic               frame_err;
    logic               busy;

    modport master (
        output en_rx, rx,
        input  data_out, u_rx_done, frame_err, busy
    );

    modport slave (
        input  en_rx, rx,
        output data_out, u_rx_done, frame_err, busy
    );

endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: single-byte UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN).
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   en_rx         - enable; low forces IDLE on the next cycle
//   rx            - raw asynchronous serial line
//   rx_s          - synchronized line (for the idle timeout in the top)
//   start_edge    - falling edge seen while IDLE
//   frame_active  - FSM not IDLE
//   byte_valid    - one-cycle pulse, byte_data holds a good byte
//   byte_err      - one-cycle pulse on bad stop bit (or bad parity)
//   byte_data     - received byte, LSB first on the line
// Optional feature macro: UART_RX_PARITY_EN.
module uart_rx_byte
    import uart_aes_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_rx,
    input  logic              rx,
    output logic              rx_s,
    output logic              start_edge,
    output logic              frame_active,
    output logic              byte_valid,
    output logic              byte_err,
    output logic [BYTE_W-1:0] byte_data
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    rx_state_t         state, state_nxt;
    logic              rx_meta, rx_s_d;
    logic [TW-1:0]     bit_timer;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shreg;
    logic              tick, fall, par_bad;

    // Synchronizer and edge-detect flops idle high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;
    // Start bit is sampled at half a bit; every later sample is a full bit after that.
    assign tick = (state == RX_START) ? (bit_timer == HALF_M1)
                                      : ((state != RX_IDLE) && (bit_timer == FULL_M1));

    always_ff @(posedge clk) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (tick) state_nxt = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_RX_PARITY_EN
            RX_DATA:   if (tick && bit_idx == 3'd7) state_nxt = RX_PARITY;
            RX_PARITY: if (tick) state_nxt = RX_STOP;
`else
            RX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = RX_STOP;
`endif
            RX_STOP:  if (tick) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
        if (!en_rx) state_nxt = RX_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_timer <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            if (state == RX_IDLE || tick) bit_timer <= '0;
            else                          bit_timer <= bit_timer + 1'b1;

            if (state == RX_IDLE) begin
                bit_idx <= '0;
            end else if (state == RX_DATA && tick) begin
                shreg   <= {rx_s, shreg[BYTE_W-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must have an even number of ones.
    always_ff @(posedge clk) begin
        if (reset)                            par_bad <= 1'b0;
        else if (state == RX_PARITY && tick)  par_bad <= ^{shreg, rx_s};
        else if (state == RX_IDLE)            par_bad <= 1'b0;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        byte_valid   = 1'b0;
        byte_err     = 1'b0;
        start_edge   = (state == RX_IDLE) && fall;
        frame_active = (state != RX_IDLE);
        if (state == RX_STOP && tick && en_rx) begin
            byte_valid = rx_s & ~par_bad;
            byte_err   = ~rx_s | par_bad;
        end
    end

    assign byte_data = shreg;

endmodule

// File: rtl/uart_rx_block128.sv
// uart_rx_block128: packs 16 received UART bytes into one 128-bit block.
//   clk, reset - rising-edge clock, synchronous active-high reset
//   bus        - uart_rx_block128_if.slave: en_rx, rx in; data_out, u_rx_done,
//                frame_err, busy out
// Parameters: CLKS_PER_BIT (>= 4), IDLE_TIMEOUT_BITS (idle bit periods before a
// partial block is dropped).
// Optional feature macro: UART_RX_PARITY_EN (handled inside uart_rx_byte).
module uart_rx_block128
    import uart_aes_pkg::*;
#(
    parameter int CLKS_PER_BIT      = 16,
    parameter int IDLE_TIMEOUT_BITS = 32
) (
    input logic               clk,
    input logic               reset,
    uart_rx_block128_if.slave bus
);

    localparam int TO_LIMIT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TOW      = $clog2(TO_LIMIT);
    localparam logic [TOW-1:0]        TO_LAST  = TOW'(TO_LIMIT - 1);
    localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(BLOCK_BYTES - 1);

    logic                  rx_s, start_edge, frame_active, byte_valid, byte_err;
    logic [BYTE_W-1:0]     byte_data;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [TOW-1:0]        to_cnt;
    logic [BYTE_W-1:0]     slots [BLOCK_BYTES];
    logic [BLOCK_W-1:0]    block_next, data_out_q;
    logic                  done_q, err_q;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .en_rx        (bus.en_rx),
        .rx           (bus.rx),
        .rx_s         (rx_s),
        .start_edge   (start_edge),
        .frame_active (frame_active),
        .byte_valid   (byte_valid),
        .byte_err     (byte_err),
        .byte_data    (byte_data)
    );

    // The 16th byte bypasses the slot store so data_out loads on the acceptance edge.
    always_comb begin
        block_next = '0;
        for (int unsigned i = 0; i < unsigned'(BLOCK_BYTES - 1); i++)
            block_next[BLOCK_W - 1 - i * BYTE_W -: BYTE_W] = slots[i];
        block_next[BYTE_W-1:0] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            to_cnt     <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            slots      <= '{default: '0};
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (!bus.en_rx) begin
                byte_cnt <= '0;
                to_cnt   <= '0;
            end else if (byte_err) begin
                byte_cnt <= '0;
                to_cnt   <= '0;
                err_q    <= 1'b1;
            end else if (byte_valid) begin
                slots[byte_cnt] <= byte_data;
                byte_cnt        <= byte_cnt + 1'b1;
                to_cnt          <= '0;
                if (byte_cnt == CNT_LAST) begin
                    data_out_q <= block_next;
                    done_q     <= 1'b1;
                end
            end else if (start_edge || frame_active || byte_cnt == '0) begin
                to_cnt <= '0;
            end else if (rx_s) begin
                // Idle line with a partial block: drop it after the timeout.
                if (to_cnt == TO_LAST) begin
                    byte_cnt <= '0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.u_rx_done = done_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = frame_active || (byte_cnt != '0);

endmodule
